// File: rtl/utopia_pkg.sv
// Shared UTOPIA-1 cell field widths and the TX arbiter state encoding.
package utopia_pkg;

    localparam int GFC_W         = 4;
    localparam int VPI_W         = 8;
    localparam int VCI_W         = 16;
    localparam int PT_W          = 3;
    localparam int HEC_W         = 8;
    localparam int PAYLOAD_BYTES = 48;
    localparam int PAYLOAD_W     = PAYLOAD_BYTES * 8;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/utopia1_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping at N_PORTS.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic w_found;
    int   w_idx;

    assign any = |req;

    // Walk N_PORTS candidates starting at last+1; the first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        winner  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_idx = (int'(last) + k) % N_PORTS;
            if (!w_found && req[SEL_W'(w_idx)]) begin
                w_found = 1'b1;
                winner  = SEL_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/utopia1_tx_arbiter.sv
// Round-robin sharing of one UTOPIA-1 TX engine among N_PORTS cell sources.
// Per-source cell counters are built only when UTOPIA_TX_ARB_STATS_EN is defined.
module utopia1_tx_arbiter
    import utopia_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int SEL_W   = $clog2(N_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PORTS-1:0]             req,
    output logic [N_PORTS-1:0]             ack,
    input  logic [GFC_W*N_PORTS-1:0]       in_GFC,
    input  logic [VPI_W*N_PORTS-1:0]       in_VPI,
    input  logic [VCI_W*N_PORTS-1:0]       in_VCI,
    input  logic [N_PORTS-1:0]             in_CLP,
    input  logic [PT_W*N_PORTS-1:0]        in_PT,
    input  logic [HEC_W*N_PORTS-1:0]       in_HEC,
    input  logic [PAYLOAD_W*N_PORTS-1:0]   in_Payload,
    output logic                           txreq,
    input  logic                           txack,
    output logic [GFC_W-1:0]               uni_GFC,
    output logic [VPI_W-1:0]               uni_VPI,
    output logic [VCI_W-1:0]               uni_VCI,
    output logic                           uni_CLP,
    output logic [PT_W-1:0]                uni_PT,
    output logic [HEC_W-1:0]               uni_HEC,
    output logic [PAYLOAD_W-1:0]           uni_Payload,
    output logic                           busy,
    output logic [SEL_W-1:0]               grant_id,
    output logic [CNT_W*N_PORTS-1:0]       cell_cnt
);

    arb_state_t            r_state;
    logic                  r_txreq;
    logic                  r_busy;
    logic [N_PORTS-1:0]    r_ack;
    logic [SEL_W-1:0]      r_last;
    logic [SEL_W-1:0]      r_grant;
    logic [GFC_W-1:0]      r_gfc;
    logic [VPI_W-1:0]      r_vpi;
    logic [VCI_W-1:0]      r_vci;
    logic                  r_clp;
    logic [PT_W-1:0]       r_pt;
    logic [HEC_W-1:0]      r_hec;
    logic [PAYLOAD_W-1:0]  r_payload;

    logic                  w_any;
    logic [SEL_W-1:0]      w_winner;
    logic                  w_done;

    rr_pick #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_done = (r_state == ST_BUSY) && txack;

    // The uni_* registers load only in IDLE, so the TX engine sees a frozen cell
    // from txreq rising until the cycle after txack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_txreq   <= 1'b0;
            r_busy    <= 1'b0;
            r_ack     <= '0;
            r_last    <= SEL_W'(N_PORTS - 1);
            r_grant   <= '0;
            r_gfc     <= '0;
            r_vpi     <= '0;
            r_vci     <= '0;
            r_clp     <= 1'b0;
            r_pt      <= '0;
            r_hec     <= '0;
            r_payload <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_gfc     <= in_GFC[w_winner*GFC_W +: GFC_W];
                        r_vpi     <= in_VPI[w_winner*VPI_W +: VPI_W];
                        r_vci     <= in_VCI[w_winner*VCI_W +: VCI_W];
                        r_clp     <= in_CLP[w_winner];
                        r_pt      <= in_PT[w_winner*PT_W +: PT_W];
                        r_hec     <= in_HEC[w_winner*HEC_W +: HEC_W];
                        r_payload <= in_Payload[w_winner*PAYLOAD_W +: PAYLOAD_W];
                        r_grant   <= w_winner;
                        r_txreq   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (txack) begin
                        r_txreq <= 1'b0;
                        r_ack   <= {{(N_PORTS-1){1'b0}}, 1'b1} << r_grant;
                        r_last  <= r_grant;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_txreq <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UTOPIA_TX_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [N_PORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_done) begin
            r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
        assign cell_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`else
    assign cell_cnt = '0;
`endif

    assign ack         = r_ack;
    assign txreq       = r_txreq;
    assign busy        = r_busy;
    assign grant_id    = r_grant;
    assign uni_GFC     = r_gfc;
    assign uni_VPI     = r_vpi;
    assign uni_VCI     = r_vci;
    assign uni_CLP     = r_clp;
    assign uni_PT      = r_pt;
    assign uni_HEC     = r_hec;
    assign uni_Payload = r_payload;

endmodule

// File: doc/utopia1_tx_arbiter.md
# utopia1_tx_arbiter

Round-robin scheduler that shares one UTOPIA-1 ATM cell transmitter among `N_PORTS` cell sources in the squat4 NNI datapath. Each source presents a complete cell: header fields plus a 48-byte payload. The arbiter grants one source, latches that cell, and drives the transmitter's `txreq`/`txack` handshake. It returns a one-cycle `ack` to the source whose cell has been sent. It sits between the per-port cell generators and the UTOPIA-1 TX engine.

## Interface
Parameters:
- `N_PORTS`, default 4: number of requesting sources (2..8).
- `SEL_W`, default `$clog2(N_PORTS)`: width of the grant index.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `N_PORTS`: per-source request, level. The source holds it until it sees its `ack` bit.
- `ack` out `N_PORTS`: per-source one-cycle pulse meaning "cell transmitted".
- `in_GFC` in 4·N, `in_VPI` in 8·N, `in_VCI` in 16·N, `in_CLP` in N, `in_PT` in 3·N, `in_HEC` in 8·N, `in_Payload` in 384·N: flattened per-source cell fields; source i occupies slice i.
- `txreq` out 1: request to the TX engine.
- `txack` in 1: one-cycle completion pulse from the TX engine.
- `uni_GFC` out 4, `uni_VPI` out 8, `uni_VCI` out 16, `uni_CLP` out 1, `uni_PT` out 3, `uni_HEC` out 8, `uni_Payload` out 384: latched cell fields to the TX engine.
- `busy` out 1: a cell is in flight (state BUSY or DRAIN).
- `grant_id` out `SEL_W`: index of the current or last granted source.
- `cell_cnt` out 16·N: per-source transmitted-cell counters (see Configuration).

## Operation
State machine:
- IDLE
  - If `req` is 0, stay.
  - Otherwise pick the winner by round-robin, starting the search at `last+1` mod N and wrapping.
  - Latch the winner's fields into the `uni_*` registers; `grant_id` <= winner; `txreq` <= 1; go to BUSY.
- BUSY
  - Hold `txreq` and all `uni_*` outputs constant.
  - On `txack`: `txreq` <= 0; `ack[grant_id]` <= 1; `last` <= `grant_id`; increment `cell_cnt[grant_id]`; go to DRAIN.
- DRAIN
  - `ack` <= 0; go to IDLE.
  - This one-cycle gap guarantees the TX engine's idle state samples `txreq` low before any new request.

Rules:
- `uni_*` fields are stable from `txreq` rising until the cycle after `txack`. The TX engine reads header fields live during transmission, so this stability is mandatory.
- `txack` in IDLE or DRAIN is ignored: no ack, no count.
- A source dropping `req` while granted does not abort the cell. It still receives `ack` when `txack` arrives.
- `req` bits of non-granted sources may change freely. Only the value present in IDLE matters.
- When only one source is requesting, it wins every round (back-to-back cells).
- `N_PORTS` not a power of two: indices ≥ N are never granted, and the pointer wraps at N.
- Reset values:
  - `txreq`=0, `ack`=0, `busy`=0, `grant_id`=0, all `uni_*`=0, `cell_cnt`=0.
  - `last`=N−1, so source 0 has first priority.
  - State is IDLE.
- Reset mid-cell: everything returns to the reset values immediately. The TX engine is reset by the same system reset and is not handshaken.

## Timing
- Grant latency: `req` seen in IDLE at cycle t → `txreq`=1 with valid `uni_*` at t+1.
- `txack` at cycle t → `txreq`=0 and `ack[i]`=1 at t+1 → IDLE at t+2 → earliest next `txreq` at t+3.
- `ack` is exactly one cycle wide, registered.
- `busy` = state ≠ IDLE, registered with the state.
- No combinational path from any input to any output.

## Configuration
`UTOPIA_TX_ARB_STATS_EN`:
- Defined: per-source 16-bit `cell_cnt` counters are implemented. They increment on each `ack` and wrap at 0xFFFF→0.
- Undefined: the counter logic is not built. `cell_cnt` is tied to 0 and the port list is unchanged.

## Structure
- Shared package `utopia_pkg` holds:
  - cell field width constants: GFC 4, VPI 8, VCI 16, PT 3, HEC 8, payload bytes 48;
  - the arbiter state enum {IDLE, BUSY, DRAIN}.
- One sub-module, `rr_pick`: a purely combinational round-robin picker. Inputs: `req`, `last`. Outputs: `any`, `winner`.

## Test plan
- Single source: `req`=4'b0100; TX model returns `txack` 70 cycles after `txreq` → `grant_id`=2, `uni_VPI` = `in_VPI[23:16]`, `ack`=4'b0100 for one cycle at `txack`+1, `cell_cnt[2]`=1.
- All four sources requesting continuously → grant order 0,1,2,3,0. Each `txreq` rises exactly 3 cycles after the previous `txack`.
- Field stability: change `in_*` of the granted source every cycle during BUSY → `uni_*` stay at the values latched at grant until DRAIN.
- Spurious `txack` pulse while IDLE with `req`=0 → no `ack`, counters unchanged, state stays IDLE.
- Assert `rst` in BUSY after 20 cycles → next cycle `txreq`=0, `busy`=0, `uni_*`=0. After release with `req`=4'b1000, source 3 is granted and source 0 has priority next.
- Counter wrap (STATS_EN defined): preload or run 65536 cells on source 1 → `cell_cnt[1]` wraps to 0. With the macro undefined, `cell_cnt` reads 0 throughout.
